// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and defaults for the cache/memory burst arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cache_mem_arbiter_pkg;

  localparam int ARB_WORD       = 32;
  localparam int ARB_LINE_WORDS = 4;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_RADDR = 3'd1,
    ARB_RDATA = 3'd2,
    ARB_WADDR = 3'd3,
    ARB_WDATA = 3'd4,
    ARB_WRESP = 3'd5
  } arb_state_e;

  typedef enum logic {
    ARB_SRC_I = 1'b0,
    ARB_SRC_D = 1'b1
  } arb_src_e;

  // One-hot grant produced by the picker.
  typedef struct packed {
    logic d_wr;
    logic d_rd;
    logic i_rd;
  } arb_grant_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of cache request/return signals and the AXI-style memory port.
// Latency: none (wiring only).
// Backpressure: carried by the *_ready / *_req signals inside.
interface cache_mem_arbiter_if #(
  parameter int WORD       = cache_mem_arbiter_pkg::ARB_WORD,
  parameter int LINE_WORDS = cache_mem_arbiter_pkg::ARB_LINE_WORDS
);

  // ICache refill
  logic                       i_rd_req;
  logic [WORD-1:0]            i_rd_addr;
  logic                       i_rd_ack;
  logic                       i_rd_valid;
  logic [WORD-1:0]            i_rd_data;
  logic                       i_rd_last;
  // DCache refill
  logic                       d_rd_req;
  logic [WORD-1:0]            d_rd_addr;
  logic                       d_rd_ack;
  logic                       d_rd_valid;
  logic [WORD-1:0]            d_rd_data;
  logic                       d_rd_last;
  // DCache write-back
  logic                       d_wr_req;
  logic [WORD-1:0]            d_wr_addr;
  logic [WORD*LINE_WORDS-1:0] d_wr_line;
  logic                       d_wr_ack;
  logic                       d_wr_done;
  // Memory read address / data
  logic                       mem_ar_valid;
  logic                       mem_ar_ready;
  logic [WORD-1:0]            mem_ar_addr;
  logic [7:0]                 mem_ar_len;
  logic                       mem_r_valid;
  logic                       mem_r_ready;
  logic [WORD-1:0]            mem_r_data;
  logic                       mem_r_last;
  // Memory write address / data / response
  logic                       mem_aw_valid;
  logic                       mem_aw_ready;
  logic [WORD-1:0]            mem_aw_addr;
  logic [7:0]                 mem_aw_len;
  logic                       mem_w_valid;
  logic                       mem_w_ready;
  logic [WORD-1:0]            mem_w_data;
  logic                       mem_w_last;
  logic                       mem_b_valid;
  logic                       mem_b_ready;

  // Arbiter view: it serves the caches and masters the memory port.
  modport master (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
    input  d_wr_req, d_wr_addr, d_wr_line,
    input  mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last,
    input  mem_aw_ready, mem_w_ready, mem_b_valid,
    output i_rd_ack, i_rd_valid, i_rd_data, i_rd_last,
    output d_rd_ack, d_rd_valid, d_rd_data, d_rd_last,
    output d_wr_ack, d_wr_done,
    output mem_ar_valid, mem_ar_addr, mem_ar_len, mem_r_ready,
    output mem_aw_valid, mem_aw_addr, mem_aw_len,
    output mem_w_valid, mem_w_data, mem_w_last, mem_b_ready
  );

  // Environment view: caches plus memory model.
  modport slave (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
    output d_wr_req, d_wr_addr, d_wr_line,
    output mem_ar_ready, mem_r_valid, mem_r_data, mem_r_last,
    output mem_aw_ready, mem_w_ready, mem_b_valid,
    input  i_rd_ack, i_rd_valid, i_rd_data, i_rd_last,
    input  d_rd_ack, d_rd_valid, d_rd_data, d_rd_last,
    input  d_wr_ack, d_wr_done,
    input  mem_ar_valid, mem_ar_addr, mem_ar_len, mem_r_ready,
    input  mem_aw_valid, mem_aw_addr, mem_aw_len,
    input  mem_w_valid, mem_w_data, mem_w_last, mem_b_ready
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_pick.sv
// Combinational requester picker: write-back first, then round-robin I/D refill.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller only samples the grant while idle.
module arb_rr_pick
  import cache_mem_arbiter_pkg::*;
(
  input  logic       d_wr_req,
  input  logic       d_rd_req,
  input  logic       i_rd_req,
  input  arb_src_e   rr_last,
  output arb_grant_t grant
);

  // Write-back beats any read; contested reads go to the side not served last.
  always_comb begin
    grant = '0;
    if (d_wr_req) begin
      grant.d_wr = 1'b1;
    end else if (i_rd_req && d_rd_req) begin
      if (rr_last == ARB_SRC_D) grant.i_rd = 1'b1;
      else                      grant.d_rd = 1'b1;
    end else if (i_rd_req) begin
      grant.i_rd = 1'b1;
    end else if (d_rd_req) begin
      grant.d_rd = 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between ICache refill, DCache refill and DCache write-back.
// Latency: ack 1 cycle after request sampled; read beats forwarded with 0 added cycles.
// Backpressure: one transaction at a time; waits on ar/aw/w ready and r/b valid.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int WORD       = ARB_WORD,
  parameter int LINE_WORDS = ARB_LINE_WORDS
) (
  input logic                 clk,
  input logic                 rst,
  cache_mem_arbiter_if.master bus
);

  localparam int               CNT_W      = $clog2(LINE_WORDS);
  localparam int               OFF_W      = $clog2(LINE_WORDS * 4);
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(LINE_WORDS - 1);
  localparam logic [7:0]       BURST_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [WORD-1:0]  ALIGN_MASK = ~((WORD'(1) << OFF_W) - WORD'(1));

  arb_state_e                 state_q, state_d;
  arb_src_e                   src_q, rr_last_q;
  logic [CNT_W-1:0]           beat_q;
  logic [WORD-1:0]            addr_q;
  logic [WORD*LINE_WORDS-1:0] line_q;
  logic                       i_ack_q, d_ack_q, w_ack_q;
  arb_grant_t                 grant;

  logic ar_valid, aw_valid, w_valid, r_ready, b_ready, wr_done, beat_adv;
  logic rd_i, rd_d, last_beat;

  arb_rr_pick u_pick (
    .d_wr_req (bus.d_wr_req),
    .d_rd_req (bus.d_rd_req),
    .i_rd_req (bus.i_rd_req),
    .rr_last  (rr_last_q),
    .grant    (grant)
  );

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ARB_IDLE;
    else      state_q <= state_d;
  end

  // Next state and memory-side handshake strobes.
  always_comb begin
    state_d  = state_q;
    ar_valid = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    r_ready  = 1'b0;
    b_ready  = 1'b0;
    wr_done  = 1'b0;
    beat_adv = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant.d_wr)                    state_d = ARB_WADDR;
        else if (grant.d_rd || grant.i_rd) state_d = ARB_RADDR;
      end
      ARB_RADDR: begin
        ar_valid = 1'b1;
        if (bus.mem_ar_ready) state_d = ARB_RDATA;
      end
      ARB_RDATA: begin
        r_ready  = 1'b1;
        beat_adv = bus.mem_r_valid;
        // Completion is decided by the local beat count, not mem_r_last.
        if (bus.mem_r_valid && last_beat) state_d = ARB_IDLE;
      end
      ARB_WADDR: begin
        aw_valid = 1'b1;
        if (bus.mem_aw_ready) state_d = ARB_WDATA;
      end
      ARB_WDATA: begin
        w_valid  = 1'b1;
        beat_adv = bus.mem_w_ready;
        if (bus.mem_w_ready && last_beat) state_d = ARB_WRESP;
      end
      ARB_WRESP: begin
        b_ready = 1'b1;
        if (bus.mem_b_valid) begin
          wr_done = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant capture (ack pulse, aligned address, victim line, source) and beat counting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_q    <= '0;
      rr_last_q <= ARB_SRC_D;
      src_q     <= ARB_SRC_I;
      addr_q    <= '0;
      line_q    <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      w_ack_q   <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      w_ack_q <= 1'b0;
      if (state_q == ARB_IDLE) begin
        beat_q <= '0;
        if (grant.d_wr) begin
          w_ack_q <= 1'b1;
          addr_q  <= bus.d_wr_addr & ALIGN_MASK;
          line_q  <= bus.d_wr_line;
        end else if (grant.d_rd) begin
          d_ack_q   <= 1'b1;
          addr_q    <= bus.d_rd_addr & ALIGN_MASK;
          src_q     <= ARB_SRC_D;
          rr_last_q <= ARB_SRC_D;
        end else if (grant.i_rd) begin
          i_ack_q   <= 1'b1;
          addr_q    <= bus.i_rd_addr & ALIGN_MASK;
          src_q     <= ARB_SRC_I;
          rr_last_q <= ARB_SRC_I;
        end
      end else if (beat_adv) begin
        // Wraps to 0 on the final beat since the counter is exactly log2(LINE_WORDS) wide.
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // The memory's own last flag must agree with the local beat count.
  always_ff @(posedge clk) begin
    if (rst && state_q == ARB_RDATA && bus.mem_r_valid) begin
      assert (bus.mem_r_last == last_beat);
    end
  end

  assign last_beat = (beat_q == LAST_BEAT);
  assign rd_i      = r_ready && bus.mem_r_valid && (src_q == ARB_SRC_I);
  assign rd_d      = r_ready && bus.mem_r_valid && (src_q == ARB_SRC_D);

  assign bus.i_rd_ack   = i_ack_q;
  assign bus.i_rd_valid = rd_i;
  assign bus.i_rd_data  = rd_i ? bus.mem_r_data : '0;
  assign bus.i_rd_last  = rd_i && last_beat;

  assign bus.d_rd_ack   = d_ack_q;
  assign bus.d_rd_valid = rd_d;
  assign bus.d_rd_data  = rd_d ? bus.mem_r_data : '0;
  assign bus.d_rd_last  = rd_d && last_beat;

  assign bus.d_wr_ack   = w_ack_q;
  assign bus.d_wr_done  = wr_done;

  assign bus.mem_ar_valid = ar_valid;
  assign bus.mem_ar_addr  = ar_valid ? addr_q : '0;
  assign bus.mem_ar_len   = ar_valid ? BURST_LEN : 8'd0;
  assign bus.mem_r_ready  = r_ready;

  assign bus.mem_aw_valid = aw_valid;
  assign bus.mem_aw_addr  = aw_valid ? addr_q : '0;
  assign bus.mem_aw_len   = aw_valid ? BURST_LEN : 8'd0;
  assign bus.mem_w_valid  = w_valid;
  assign bus.mem_w_data   = w_valid ? line_q[int'(beat_q)*WORD +: WORD] : '0;
  assign bus.mem_w_last   = w_valid && last_beat;
  assign bus.mem_b_ready  = b_ready;

endmodule
